// File: rtl/hamming74_encoder_stream.sv
// hamming74_encoder_stream
//   Streams 4-bit nibbles into Hamming(7,4) codewords for the downstream
//   decoder. Nibbles enter over a valid/ready handshake and wait in a
//   DEPTH-entry FIFO. The FIFO head is encoded combinationally and loaded
//   into a registered valid/ready output stage. Completed output handshakes
//   are counted in a wrapping counter.
//
//   Optional build macro HAMMING_ERR_INJECT_EN adds a single-shot bit-flip
//   injector, used to exercise the decoder's correction path.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     data_in holds a nibble to accept
//   in_ready     a nibble can be accepted this cycle
//   data_in      nibble: bit0=d1 .. bit3=d4
//   out_valid    hammingcode holds a valid codeword
//   out_ready    downstream consumes the codeword this cycle
//   err_arm      (HAMMING_ERR_INJECT_EN) latch err_pos and arm the injector
//   err_pos      (HAMMING_ERR_INJECT_EN) bit index to flip; 7 flips nothing
//   hammingcode  codeword: bit k-1 = Hamming position k
//   fifo_count   FIFO occupancy, not counting the output register
//   words_sent   completed output handshakes, wraps silently

// Pure combinational Hamming(7,4) encoder.
module hamming74_enc (
  input  logic [3:0] d,
  output logic [6:0] code
);
  // {d4, d3, d2, p4, d1, p2, p1}
  assign code = {d[3], d[2], d[1],
                 d[1] ^ d[2] ^ d[3],
                 d[0],
                 d[0] ^ d[2] ^ d[3],
                 d[0] ^ d[1] ^ d[3]};
endmodule

module hamming74_encoder_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic                         err_arm,
  input  logic [2:0]                   err_pos,
`endif
  output logic [6:0]                   hammingcode,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [CNT_W-1:0]             words_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][3:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  push, load, fire;
  logic [6:0]            enc_code, flip_mask;

  // Ready comes from the registered count only: a pop in the same cycle
  // does not free a slot for the incoming nibble.
  assign in_ready   = !reset && (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fire       = out_valid && out_ready;
  // Output register is free when empty or being drained this cycle.
  assign load       = (count != '0) && (!out_valid || out_ready);
  assign fifo_count = count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  hamming74_enc u_enc (
    .d    (mem[rd_ptr]),
    .code (enc_code)
  );

`ifdef HAMMING_ERR_INJECT_EN
  logic       err_armed;
  logic [2:0] err_pos_q;

  // Shifting into 8 bits and truncating to 7 makes position 7 a no-op.
  assign flip_mask = err_armed ? 7'(8'd1 << err_pos_q) : 7'd0;

  // A new arm takes priority over the disarm caused by a load in the same
  // cycle; that load still uses the previously stored position.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_armed <= 1'b0;
      err_pos_q <= '0;
    end else if (err_arm) begin
      err_armed <= 1'b1;
      err_pos_q <= err_pos;
    end else if (load) begin
      err_armed <= 1'b0;
    end
  end
`else
  assign flip_mask = 7'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      hammingcode <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      hammingcode <= enc_code ^ flip_mask;
    end else if (fire) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     words_sent <= '0;
    else if (fire) words_sent <= words_sent + CNT_W'(1);
  end

endmodule

// File: tb/tb_hamming74_encoder_stream.sv
module tb_hamming74_encoder_stream;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready;
  logic [3:0] data_in;
  logic       in_ready, out_valid;
  logic [6:0] hammingcode;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic [CNT_W-1:0] words_sent;
`ifdef HAMMING_ERR_INJECT_EN
  logic       err_arm;
  logic [2:0] err_pos;
`endif

  hamming74_encoder_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef HAMMING_ERR_INJECT_EN
    .err_arm     (err_arm),
    .err_pos     (err_pos),
`endif
    .hammingcode (hammingcode),
    .fifo_count  (fifo_count),
    .words_sent  (words_sent)
  );

  always #5 clk = ~clk;

  // Hand-encoded vectors: {d4,d3,d2,p4,d1,p2,p1}
  localparam logic [3:0] VD [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0110,
                                    4'b1010, 4'b0101, 4'b1111, 4'b0001};
  localparam logic [6:0] VC [8] = '{7'b0011001, 7'b0101010, 7'b1001011, 7'b0110011,
                                    7'b1010010, 7'b0101101, 7'b1111111, 7'b0000111};

  int n_vec = 0;
  int n_err = 0;
  logic [6:0] sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic push(input logic [3:0] d, input logic [6:0] exp);
    int n = 0;
    in_valid = 1'b1;
    data_in  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        n_vec++; n_err++;
        $display("FAIL push_timeout: in_ready stuck low for data %b", d);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    sb.push_back(exp);
    #1 in_valid = 1'b0;
    data_in = 4'bx;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_queue_empty", sb.size(), 0);
    @(negedge clk);
    chk("drain_out_valid", out_valid, 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every handshake, checks stall stability and counter.
  int         exp_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [6:0] prev_code;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_cnt    = 0;
        prev_stall = 1'b0;
      end else begin
        chk("words_sent", words_sent, exp_cnt);
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_code", hammingcode, prev_code);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_word: got %b expected none", hammingcode);
          end else begin
            chk("codeword", hammingcode, sb.pop_front());
          end
          exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        end
        prev_stall = out_valid && !out_ready;
        prev_code  = hammingcode;
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = 4'b0;
`ifdef HAMMING_ERR_INJECT_EN
    err_arm = 1'b0; err_pos = 3'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_code", hammingcode, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_words", words_sent, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single word, latency
    out_ready = 1'b1;
    push(4'b1011, 7'b1010101);
    @(negedge clk);
    chk("lat_not_yet", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_code", hammingcode, 7'b1010101);
    @(posedge clk); #1;
    drain();
    chk("words_after_one", words_sent, 1);

    // Back-to-back
    push(4'b0000, 7'b0000000);
    push(4'b1111, 7'b1111111);
    push(4'b0001, 7'b0000111);
    drain();

    // Fill under stall
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(VD[i], VC[i]);
    @(negedge clk);
    chk("full_count", fifo_count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(VD[i], VC[i]);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_words", words_sent, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(4'b1011, 7'b1010101);
    drain();

    // Counter wrap: 1 + 8 handshakes with a 3-bit counter
    for (int i = 0; i < 8; i++) push(VD[i], VC[i]);
    drain();
    chk("words_wrap", words_sent, 1);

`ifdef HAMMING_ERR_INJECT_EN
    err_arm = 1'b1; err_pos = 3'd0;
    @(posedge clk); #1 err_arm = 1'b0;
    push(4'b1011, 7'b1010100);
    push(4'b1011, 7'b1010101);
    drain();
    err_arm = 1'b1; err_pos = 3'd6;
    @(posedge clk); #1 err_arm = 1'b0;
    push(4'b1011, 7'b0010101);
    drain();
    err_arm = 1'b1; err_pos = 3'd7;
    @(posedge clk); #1 err_arm = 1'b0;
    push(4'b1011, 7'b1010101);
    drain();
    err_arm = 1'b1; err_pos = 3'd3;
    @(posedge clk); #1 err_pos = 3'd1;
    @(posedge clk); #1 err_arm = 1'b0;
    push(4'b1011, 7'b1010111);
    push(4'b1011, 7'b1010101);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hamming74_encoder_stream.md
Name: hamming74_encoder_stream

Overview:
- Upstream neighbour of the Hamming(7,4) decoder.
- Accepts 4-bit data nibbles over a valid/ready handshake and buffers them in a small FIFO.
- Encodes each nibble into a 7-bit Hamming codeword and presents it on a registered valid/ready output that drives the decoder's hammingcode input.
- Counts emitted codewords; can optionally inject single-bit errors to exercise the decoder's correction path.

Parameters:
- DEPTH, 4, input FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  data_in holds a nibble to accept
- in_ready  output  1  block can accept a nibble this cycle
- data_in  input  4  data nibble; bit0=d1, bit1=d2, bit2=d3, bit3=d4
- out_valid  output  1  hammingcode holds a valid codeword
- out_ready  input  1  downstream consumes the codeword this cycle
- hammingcode  output  7  encoded word; bit k-1 = Hamming position k
- fifo_count  output  $clog2(DEPTH+1)  FIFO occupancy; excludes the output register
- words_sent  output  CNT_W  count of completed output handshakes; wraps

Behaviour:
- Single clock domain; reset is synchronous and active-high; clock port is clk, reset port is reset.
- Reset values: out_valid=0, hammingcode=7'b0000000, fifo_count=0, words_sent=0, read/write pointers=0.
  - in_ready is 0 while reset is high.
- Codeword mapping:
  - bit0=p1=d1^d2^d4
  - bit1=p2=d1^d3^d4
  - bit2=d1
  - bit3=p4=d2^d3^d4
  - bit4=d2, bit5=d3, bit6=d4
- Input side:
  - in_ready = !reset && (fifo_count < DEPTH), derived from the registered count.
  - No same-cycle pop credit: when full, in_ready stays 0 even if a pop occurs that cycle.
  - Push happens on a clock edge with in_valid && in_ready.
- Output stage:
  - The output register loads the encoded FIFO head when fifo_count>0 && (!out_valid || out_ready).
  - Encoding is done combinationally on the FIFO head before the register.
- Latency: a nibble accepted at edge E appears with out_valid=1 after edge E+1 at the earliest (empty FIFO, output free).
- Throughput: one word per cycle sustained when out_ready=1.
- Hold rule: while out_valid && !out_ready, hammingcode and out_valid hold stable.
- Drain: on a handshake with an empty FIFO, out_valid deasserts after the edge.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Ordering is strictly FIFO.
- words_sent increments by 1 on each out_valid && out_ready edge. It wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation discards all buffered words and the output register. Any pending handshake in the reset cycle is ignored.
- X-free: data_in is not sampled when in_valid=0.

Optional Feature:
- Macro: HAMMING_ERR_INJECT_EN
- When defined, adds two inputs: err_arm (1 bit) and err_pos (3 bits).
  - An err_arm pulse latches err_pos into a single-shot injector.
  - The next codeword loaded into the output register has bit err_pos inverted. The injector then disarms.
  - err_pos=7 latches but flips nothing.
  - A new arm while already armed overwrites the stored position.
  - Reset disarms the injector.
- When undefined, the ports do not exist and hammingcode is always the clean encoding.

Test Plan:
- Reset, then push data_in=4'b1011 with out_ready=1 -> out_valid=1 one cycle after acceptance, hammingcode=7'b1010101, words_sent=1.
- Push 4'b0000, 4'b1111 and 4'b0001 back-to-back with out_ready=1 -> 7'b0000000, 7'b1111111 and 7'b0000111 on consecutive cycles, in order.
- Hold out_ready=0 and push DEPTH+1 nibbles -> one word in the output register; after DEPTH more pushes fifo_count=DEPTH and in_ready=0. Release out_ready -> all words drain in order; hammingcode stays stable while stalled.
- Fill part-way, assert reset for one cycle mid-stream -> out_valid=0, fifo_count=0, words_sent=0; the next pushed 4'b1011 gives 7'b1010101.
- With CNT_W=3, complete 9 handshakes -> words_sent reads 1.
- With HAMMING_ERR_INJECT_EN defined:
  - Arm err_pos=0, then push 4'b1011 -> hammingcode=7'b1010100.
  - The following 4'b1011 gives 7'b1010101.
  - Arm err_pos=6 -> 7'b0010101.
